vid_store_buffer: RTL and testbench



---
 rtl/vid_store_pkg.sv | 22 ++
 rtl/vid_store_fifo_ram.sv | 34 +++
 rtl/vid_store_buffer.sv | 135 +++++++++++++
 tb/tb_vid_store_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_store_pkg.sv
// Shared types for the video store buffer.
//   state_t       : issue FSM state
//   store_entry_t : one buffered full-line store {adr, sel, dat}
//   SEL_W         : byte-select width (one bit per data byte)
package vid_store_pkg;

  localparam int unsigned VS_AWID = 32;
  localparam int unsigned VS_DWID = 256;
  localparam int unsigned SEL_W   = VS_DWID / 8;

  typedef enum logic [0:0] {
    IDLE,
    ISSUE
  } state_t;

  typedef struct packed {
    logic [VS_AWID-1:0] adr;
    logic [SEL_W-1:0]   sel;
    logic [VS_DWID-1:0] dat;
  } store_entry_t;

endpackage

// File: rtl/vid_store_fifo_ram.sv
// Register-array storage for the store FIFO.
//   clk     : clock
//   we      : write enable
//   wr_addr : write slot
//   wr_data : entry to write
//   rd_addr : head slot
//   rd_data : head entry (combinational read)
// Pointer and occupancy tracking live in the parent.
module vid_store_fifo_ram
  import vid_store_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PtrW-1:0] wr_addr,
  input  store_entry_t    wr_data,
  input  logic [PtrW-1:0] rd_addr,
  output store_entry_t    rd_data
);

  store_entry_t mem [DEPTH];

  // Storage carries no reset; validity is tracked by the parent's pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vid_store_buffer.sv
// Store buffer between the blit master and the frame-buffer memory port.
//   clk, rst          : clock, asynchronous active-high reset
//   s_store/adr/sel/dat : store beat from the master
//   s_stall           : master must stop issuing stores
//   m_req/adr/sel/dat : registered memory request, held until m_ack
//   m_ack             : memory accepted the current request
//   count             : FIFO occupancy, not counting the entry held on m_*
//   busy              : request outstanding or FIFO non-empty
//   ovf, ovf_clr      : sticky overflow flag and its clear
// AWID/DWID must match the widths in vid_store_pkg.
module vid_store_buffer
  import vid_store_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AWID         = VS_AWID,
  parameter int unsigned DWID         = VS_DWID,
  parameter int unsigned AFULL_MARGIN = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_store,
  input  logic [AWID-1:0]   s_adr,
  input  logic [DWID/8-1:0] s_sel,
  input  logic [DWID-1:0]   s_dat,
  output logic              s_stall,
  output logic              m_req,
  output logic [AWID-1:0]   m_adr,
  output logic [DWID/8-1:0] m_sel,
  output logic [DWID-1:0]   m_dat,
  input  logic              m_ack,
  output logic [CntW-1:0]   count,
  output logic              busy,
  output logic              ovf,
  input  logic              ovf_clr
);

  state_t          state_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;

  store_entry_t wr_entry;
  store_entry_t head;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic ovf_set;
  logic [CntW-1:0] count_d;

  assign full  = (count == CntW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO drops the beat even if a pop frees a slot this same cycle.
  assign push    = s_store & ~full;
  assign ovf_set = s_store & full;

  // Pop from IDLE whenever data waits; from ISSUE only when the current
  // request is acked, giving back-to-back issue.
  assign pop = ~empty & ((state_q == IDLE) | m_ack);

  assign count_d = count + CntW'(push) - CntW'(pop);

  assign s_stall = (count >= CntW'(DEPTH - AFULL_MARGIN));
  assign busy    = (state_q != IDLE) | ~empty;

  assign wr_entry = '{adr: s_adr, sel: s_sel, dat: s_dat};

  vid_store_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      m_req    <= 1'b0;
      m_adr    <= '0;
      m_sel    <= '0;
      m_dat    <= '0;
    end else begin
      count <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        m_adr    <= head.adr;
        m_sel    <= head.sel;
        m_dat    <= head.dat;
      end

      // Set wins over clear.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            m_req   <= 1'b1;
            state_q <= ISSUE;
          end else begin
            m_req <= 1'b0;
          end
        end
        ISSUE: begin
          if (m_ack && empty) begin
            m_req   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          m_req   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_store_buffer.sv
// Directed bench for vid_store_buffer plus a scoreboarded random stretch.
module tb_vid_store_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_store;
  logic [31:0]  s_adr;
  logic [31:0]  s_sel;
  logic [255:0] s_dat;
  logic         s_stall;
  logic         m_req;
  logic [31:0]  m_adr;
  logic [31:0]  m_sel;
  logic [255:0] m_dat;
  logic         m_ack;
  logic [4:0]   count;
  logic         busy;
  logic         ovf;
  logic         ovf_clr;

  logic [319:0] m_ent;
  assign m_ent = {m_adr, m_sel, m_dat};

  int checks = 0;
  int errors = 0;

  logic [319:0] q[$];

  vid_store_buffer u_dut (
    .clk     (clk),
    .rst     (rst),
    .s_store (s_store),
    .s_adr   (s_adr),
    .s_sel   (s_sel),
    .s_dat   (s_dat),
    .s_stall (s_stall),
    .m_req   (m_req),
    .m_adr   (m_adr),
    .m_sel   (m_sel),
    .m_dat   (m_dat),
    .m_ack   (m_ack),
    .count   (count),
    .busy    (busy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ent(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [319:0] e);
    s_store = st;
    {s_adr, s_sel, s_dat} = e;
  endtask

  function automatic logic [319:0] ent(input int i);
    ent = {32'h0020_1000 + 32'(32 * i), ~32'(i), {8{32'hA500_0000 + 32'(i)}}};
  endfunction

  initial begin
    logic [319:0] e1;
    logic [319:0] er;
    logic [319:0] exp_e;
    int exp_cnt;

    rst     = 1'b1;
    m_ack   = 1'b0;
    ovf_clr = 1'b0;
    drive(1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_stall", 32'(s_stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk_ent("rst_m_ent", m_ent, '0);
    rst = 1'b0;

    // Single store, ack tied high: m_req for one cycle, two edges after push.
    m_ack = 1'b1;
    e1 = {32'h0020_1000, 32'hFFFF_FFFF, {16{16'h000F}}};
    drive(1'b1, e1);
    tick;
    drive(1'b0, '0);
    chk("single_cnt1", 32'(count), 1);
    chk("single_req0", 32'(m_req), 0);
    tick;
    chk("single_req1", 32'(m_req), 1);
    chk_ent("single_ent", m_ent, e1);
    chk("single_cnt0", 32'(count), 0);
    tick;
    chk("single_req_drop", 32'(m_req), 0);
    chk("single_busy", 32'(busy), 0);

    // Fill with ack low: first entry moves to the holding register, so 17
    // accepted pushes bring count to 16.
    m_ack = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      drive(1'b1, ent(i));
      tick;
      exp_cnt = (i == 0) ? 1 : i;
      chk("fill_count", 32'(count), 32'(exp_cnt));
      chk("fill_stall", 32'(s_stall), (exp_cnt >= 14) ? 1 : 0);
      chk("fill_req", 32'(m_req), (i > 0) ? 1 : 0);
    end
    drive(1'b0, '0);
    chk("fill_ovf", 32'(ovf), 0);
    chk_ent("fill_hold", m_ent, ent(0));

    // Overflow while full, then overflow with simultaneous ack and clear.
    drive(1'b1, ent(17));
    tick;
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 16);
    chk_ent("ovf_hold", m_ent, ent(0));
    drive(1'b1, ent(18));
    m_ack   = 1'b1;
    ovf_clr = 1'b1;
    tick;
    drive(1'b0, '0);
    chk("ovf_set_wins", 32'(ovf), 1);
    chk("ovf_ack_count", 32'(count), 15);
    chk_ent("ovf_ack_ent", m_ent, ent(1));
    for (int k = 2; k <= 16; k++) begin
      tick;
      if (k == 2) begin
        chk("ovf_clr", 32'(ovf), 0);
        ovf_clr = 1'b0;
      end
      chk("drain_req", 32'(m_req), 1);
      chk_ent("drain_ent", m_ent, ent(k));
      chk("drain_count", 32'(count), 32'(16 - k));
    end
    tick;
    chk("drain_done_req", 32'(m_req), 0);
    chk("drain_done_busy", 32'(busy), 0);
    chk("drain_ovf_stays0", 32'(ovf), 0);

    // Push coinciding with the last ack: one-cycle bubble, then reissue.
    m_ack = 1'b0;
    drive(1'b1, ent(40));
    tick;
    drive(1'b0, '0);
    tick;
    chk("last_ack_req", 32'(m_req), 1);
    chk_ent("last_ack_ent", m_ent, ent(40));
    m_ack = 1'b1;
    drive(1'b1, ent(41));
    tick;
    drive(1'b0, '0);
    chk("bubble_req", 32'(m_req), 0);
    chk("bubble_count", 32'(count), 1);
    chk("bubble_busy", 32'(busy), 1);
    tick;
    chk("reissue_req", 32'(m_req), 1);
    chk_ent("reissue_ent", m_ent, ent(41));
    tick;
    chk("reissue_done", 32'(m_req), 0);

    // Asynchronous reset mid-burst with count=7.
    m_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ent(50 + i));
      tick;
    end
    drive(1'b0, '0);
    chk("burst_count", 32'(count), 7);
    chk("burst_req", 32'(m_req), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_req", 32'(m_req), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_busy", 32'(busy), 0);
    tick;
    rst   = 1'b0;
    m_ack = 1'b1;
    drive(1'b1, ent(60));
    tick;
    drive(1'b0, '0);
    chk("post_rst_count", 32'(count), 1);
    tick;
    chk("post_rst_req", 32'(m_req), 1);
    chk_ent("post_rst_ent", m_ent, ent(60));
    tick;
    chk("post_rst_done", 32'(m_req), 0);

    // Random push/ack with a queue scoreboard; the master honours s_stall.
    for (int c = 0; c < 2000; c++) begin
      if (!s_stall && ($urandom_range(1, 0) == 1)) begin
        er[319:288] = $urandom & 32'hFFFF_FFE0;
        er[287:256] = $urandom;
        for (int j = 0; j < 8; j++) er[j*32 +: 32] = $urandom;
        drive(1'b1, er);
        q.push_back(er);
      end else begin
        drive(1'b0, '0);
      end
      m_ack = ($urandom_range(99, 0) < 30);
      if (m_req && m_ack) begin
        if (q.size() == 0) begin
          chk("rand_spurious_req", 32'(q.size()), 1);
        end else begin
          exp_e = q.pop_front();
          chk_ent("rand_order", m_ent, exp_e);
        end
      end
      tick;
      chk("rand_count_max", 32'(count > 5'd16), 0);
    end
    drive(1'b0, '0);
    m_ack = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (m_req) begin
        if (q.size() == 0) begin
          chk("rand_spurious_req", 32'(q.size()), 1);
        end else begin
          exp_e = q.pop_front();
          chk_ent("rand_drain_order", m_ent, exp_e);
        end
      end
      tick;
    end
    chk("rand_all_seen", 32'(q.size()), 0);
    chk("rand_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
